dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Data-memory access sequencer for the MEM stage. It takes one load or store per instruction from the pipeline and checks address alignment. It drives the single-port SRAM-like data bus (req/addr_ok/data_ok handshake) and stalls the pipeline until the access completes. It returns sign- or zero-extended load data, and it handles pipeline flushes without losing track of bus transactions already accepted.

## Interface
- No parameters.
- clk  input  1  system clock
- resetn  input  1  synchronous, active-low reset
- ms_valid  input  1  MEM stage holds a valid instruction
- ms_op  input  8  one-hot access op: [0]LB [1]LBU [2]LH [3]LHU [4]LW [5]SB [6]SH [7]SW; 0 = no access
- ms_addr  input  32  effective address
- ms_wdata  input  32  store source register value, unshifted
- ms_flush  input  1  exception/eret flush of MEM stage
- ms_stall  output  1  hold MEM stage
- ms_done  output  1  one-cycle completion pulse
- ms_rdata  output  32  extended load result, valid with ms_done
- ms_adel / ms_ades  output  1 each  load / store address error, valid with ms_done
- ms_badvaddr  output  32  faulting address, valid with ms_adel/ms_ades
- data_sram_req  output  1  bus request
- data_sram_wr  output  1  1 = write
- data_sram_size  output  2  0 byte, 1 half, 2 word
- data_sram_addr  output  32  byte address, unmodified
- data_sram_wstrb  output  4  byte enables; 0 for loads
- data_sram_wdata  output  32  replicated store data
- data_sram_addr_ok  input  1  request accepted this cycle
- data_sram_data_ok  input  1  response this cycle
- data_sram_rdata  input  32  raw read word

## Operation
- States: IDLE, REQ, WAIT, DONE, DISCARD.
- IDLE:
  - ms_valid & |ms_op & !ms_flush: capture op, addr and wdata.
  - Aligned access → REQ.
  - Misaligned access (half with addr[0]=1; word with addr[1:0]≠0) → DONE with ms_adel (loads) or ms_ades (stores), badvaddr = addr. No bus request is made.
- REQ:
  - data_sram_req=1; request fields come from registers and stay stable.
  - addr_ok → WAIT.
  - req is held until addr_ok even under flush.
- WAIT:
  - data_ok → DONE; capture the extended rdata.
- DONE:
  - ms_done=1 for one cycle, then → IDLE.
- DISCARD:
  - Waits in REQ-equivalent fashion for any outstanding addr_ok, then for data_ok.
  - Response is dropped, no ms_done → IDLE.
- Flush handling:
  - Flush in REQ sets a cancel flag; addr_ok then → DISCARD.
  - Flush in WAIT → DISCARD.
  - Flush in IDLE or DONE: nothing is captured.
  - A data_ok arriving in the same cycle as a flush in WAIT is consumed and dropped → IDLE.
- Store byte enables:
  - SB: wstrb = 1<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wstrb 0011 (addr[1]=0) or 1100 (addr[1]=1); wdata = {2{wdata[15:0]}}.
  - SW: wstrb 1111.
- Load extraction:
  - Byte lane = addr[1:0], half lane = addr[1].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- ms_stall = ms_valid & |ms_op & (state≠DONE); it is also 1 whenever the state is DISCARD.
- Unused data_sram_rdata bits are ignored. A data_ok outside WAIT/DISCARD is a protocol violation; the block ignores it.

## Timing
- Reset: state IDLE. All outputs are 0: req, wr, size, addr, wstrb, wdata, stall (combinational from ms_valid), done, rdata, adel, ades, badvaddr.
- Best case, with ms_valid first seen at cycle T:
  - T+1: REQ, addr_ok=1.
  - T+2: WAIT, data_ok=1.
  - T+3: ms_done.
  - T+4: IDLE; the next op is accepted.
- Misaligned access: ms_done at T+1.
- Back-to-back ops: one access in flight at most; no new request before the state returns to IDLE.
- resetn low mid-transaction: immediate return to IDLE; no pending-response tracking survives reset.

## Configuration
- DMEM_ADDR_EXC_EN defined: alignment check and AdEL/AdES reporting as above.
- DMEM_ADDR_EXC_EN undefined:
  - No check; every access goes to REQ.
  - The lane is selected from addr as given.
  - ms_adel, ms_ades and ms_badvaddr are tied 0.

## Test plan
- LB addr 0x1003, rdata 0x80FF_FF00, addr_ok/data_ok at the first opportunity → ms_done at T+3, ms_rdata 0xFFFF_FF80, size 0, wstrb 0.
- SH addr 0x2002, wdata 0x1234_ABCD → req with wr=1, size 1, wstrb 1100, data_sram_wdata 0xABCD_ABCD; stall deasserted only in DONE.
- LW addr 0x3001 (macro defined) → no data_sram_req, ms_done at T+1, ms_adel=1, badvaddr 0x3001; macro undefined → bus read issued at 0x3001, ms_adel=0.
- LHU with addr_ok delayed 3 cycles and data_ok delayed 2 → req stable for 4 cycles, ms_done exactly 1 cycle after data_ok, rdata {16'h0, rdata[31:16]} for addr[1]=1.
- ms_flush during WAIT, then a new LW presented → the old data_ok is dropped with no ms_done; the new req is issued only after that data_ok; the new result is correct.
- resetn low while in WAIT → the next cycle shows state IDLE with all outputs 0.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl_if
//   Bundles the MEM-stage handshake and the SRAM-like data bus seen by
//   dmem_access_ctrl.
//   master : the access controller (consumes ms_* requests, drives the bus)
//   slave  : the environment (pipeline MEM stage plus data memory)
//   Pipeline side : ms_valid, ms_op, ms_addr, ms_wdata, ms_flush ->
//                   ms_stall, ms_done, ms_rdata, ms_adel, ms_ades, ms_badvaddr
//   Bus side      : data_sram_req/wr/size/addr/wstrb/wdata ->
//                   data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
// ---------------------------------------------------------------------------
interface dmem_access_ctrl_if;
  logic        ms_valid;
  logic [7:0]  ms_op;
  logic [31:0] ms_addr;
  logic [31:0] ms_wdata;
  logic        ms_flush;
  logic        ms_stall;
  logic        ms_done;
  logic [31:0] ms_rdata;
  logic        ms_adel;
  logic        ms_ades;
  logic [31:0] ms_badvaddr;

  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    input  ms_valid, ms_op, ms_addr, ms_wdata, ms_flush,
    output ms_stall, ms_done, ms_rdata, ms_adel, ms_ades, ms_badvaddr,
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
    output data_sram_wstrb, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    output ms_valid, ms_op, ms_addr, ms_wdata, ms_flush,
    input  ms_stall, ms_done, ms_rdata, ms_adel, ms_ades, ms_badvaddr,
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
    input  data_sram_wstrb, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
//   MEM-stage data-memory access sequencer. Accepts one load/store per
//   instruction, checks alignment, runs one transaction at a time on the
//   req/addr_ok/data_ok data bus, stalls the pipeline until completion and
//   returns sign/zero-extended load data. Flushed accesses that already
//   reached the bus are drained (DISCARD) so no response is ever lost.
//
// Ports
//   clk    : system clock
//   resetn : synchronous active-low reset
//   bus    : dmem_access_ctrl_if.master (pipeline handshake + data bus)
//
// Configuration
//   DMEM_ADDR_EXC_EN : when defined, misaligned half/word accesses complete
//                      immediately with ms_adel/ms_ades and ms_badvaddr and
//                      never reach the bus. When undefined, every access goes
//                      to the bus and the exception outputs are tied 0.
// ---------------------------------------------------------------------------
module dmem_access_ctrl (
  input  logic               clk,
  input  logic               resetn,
  dmem_access_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DISCARD} state_t;

  state_t      state, state_next;
  logic [7:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        cancel_q;     // flush seen while the request was still unaccepted
  logic        accept;
  logic        misaligned;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;

  assign accept = (state == IDLE) && bus.ms_valid && (|bus.ms_op) && !bus.ms_flush;

`ifdef DMEM_ADDR_EXC_EN
  assign misaligned = ((bus.ms_op[2] | bus.ms_op[3] | bus.ms_op[6]) & bus.ms_addr[0]) |
                      ((bus.ms_op[4] | bus.ms_op[7]) & (|bus.ms_addr[1:0]));
`else
  assign misaligned = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // ---------------- FSM: next-state logic ----------------
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = misaligned ? DONE : REQ;
      // The request is never withdrawn; a flush only redirects where the
      // accepted transaction ends up.
      REQ:     if (bus.data_sram_addr_ok)
                 state_next = (cancel_q || bus.ms_flush) ? DISCARD : WAIT;
      // A response coinciding with a flush is consumed right here.
      WAIT:    if (bus.data_sram_data_ok) state_next = bus.ms_flush ? IDLE : DONE;
               else if (bus.ms_flush)     state_next = DISCARD;
      DONE:    state_next = IDLE;
      DISCARD: if (bus.data_sram_data_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.data_sram_req   = (state == REQ);
    bus.data_sram_wr    = |op_q[7:5];
    bus.data_sram_addr  = addr_q;
    bus.data_sram_size  = 2'd0;
    bus.data_sram_wstrb = 4'b0000;
    bus.data_sram_wdata = 32'h0;
    if (op_q[2] | op_q[3] | op_q[6]) bus.data_sram_size = 2'd1;
    if (op_q[4] | op_q[7])           bus.data_sram_size = 2'd2;
    if (op_q[5]) begin
      bus.data_sram_wstrb = 4'b0001 << addr_q[1:0];
      bus.data_sram_wdata = {4{wdata_q[7:0]}};
    end
    if (op_q[6]) begin
      bus.data_sram_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      bus.data_sram_wdata = {2{wdata_q[15:0]}};
    end
    if (op_q[7]) begin
      bus.data_sram_wstrb = 4'b1111;
      bus.data_sram_wdata = wdata_q;
    end
    bus.ms_done  = (state == DONE);
    bus.ms_rdata = rdata_q;
    // DISCARD holds the stage even if the flushed instruction has gone.
    bus.ms_stall = (bus.ms_valid && (|bus.ms_op) && (state != DONE)) || (state == DISCARD);
  end

  // ---------------- load lane extraction ----------------
  always_comb begin
    lane_b = bus.data_sram_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    lane_b = bus.data_sram_rdata[15:8];
      2'd2:    lane_b = bus.data_sram_rdata[23:16];
      2'd3:    lane_b = bus.data_sram_rdata[31:24];
      default: lane_b = bus.data_sram_rdata[7:0];
    endcase
    lane_h   = addr_q[1] ? bus.data_sram_rdata[31:16] : bus.data_sram_rdata[15:0];
    load_ext = 32'h0;   // stores capture 0
    if (op_q[0]) load_ext = {{24{lane_b[7]}}, lane_b};
    if (op_q[1]) load_ext = {24'h0, lane_b};
    if (op_q[2]) load_ext = {{16{lane_h[15]}}, lane_h};
    if (op_q[3]) load_ext = {16'h0, lane_h};
    if (op_q[4]) load_ext = bus.data_sram_rdata;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q     <= 8'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      cancel_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= bus.ms_op;
        addr_q  <= bus.ms_addr;
        wdata_q <= bus.ms_wdata;
        rdata_q <= 32'h0;
      end
      if (state == WAIT && bus.data_sram_data_ok) rdata_q <= load_ext;
      cancel_q <= (state == REQ) && !bus.data_sram_addr_ok && (cancel_q || bus.ms_flush);
    end
  end

`ifdef DMEM_ADDR_EXC_EN
  logic        adel_q;
  logic        ades_q;
  logic [31:0] badvaddr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
      badvaddr_q <= 32'h0;
    end else if (accept) begin
      adel_q     <= misaligned && (|bus.ms_op[4:0]);
      ades_q     <= misaligned && (|bus.ms_op[7:5]);
      badvaddr_q <= misaligned ? bus.ms_addr : 32'h0;
    end
  end

  assign bus.ms_adel     = adel_q;
  assign bus.ms_ades     = ades_q;
  assign bus.ms_badvaddr = badvaddr_q;
`else
  assign bus.ms_adel     = 1'b0;
  assign bus.ms_ades     = 1'b0;
  assign bus.ms_badvaddr = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
//   Directed bench for dmem_access_ctrl. Stimulus pushes expected bus
//   requests and expected completions into queues; negedge monitors pop and
//   compare whenever the DUT accepts a request or pulses ms_done. A small
//   bus responder returns addr_ok/data_ok after programmable delays.
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;

  localparam logic [7:0] OP_LB = 8'h01, OP_LBU = 8'h02, OP_LH = 8'h04, OP_LHU = 8'h08,
                         OP_LW = 8'h10, OP_SB  = 8'h20, OP_SH = 8'h40, OP_SW  = 8'h80;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  dmem_access_ctrl_if bus ();
  dmem_access_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic [31:0] badv;
  } done_exp_t;

  bus_exp_t    bus_q[$];
  done_exp_t   done_q[$];
  logic [31:0] rsp_data_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int addr_dly = 0, data_dly = 0;
  int req_cycles = 0, dcnt = 0;
  bit pend = 0;
  int req_run = 0, last_req_len = 0, overlap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- bus responder ----------------
  initial begin
    bus.data_sram_addr_ok = 1'b0;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'h5555_AAAA;
    forever begin
      @(posedge clk); #1;
      bus.data_sram_addr_ok = 1'b0;
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata   = 32'h5555_AAAA;
      if (!resetn) begin
        pend = 0;
        req_cycles = 0;
        rsp_data_q.delete();
      end else if (pend) begin
        if (dcnt == 0) begin
          bus.data_sram_data_ok = 1'b1;
          bus.data_sram_rdata   = (rsp_data_q.size() > 0) ? rsp_data_q.pop_front() : 32'h0;
          pend = 0;
        end else dcnt--;
      end else if (bus.data_sram_req) begin
        if (req_cycles == addr_dly) begin
          bus.data_sram_addr_ok = 1'b1;
          req_cycles = 0;
          pend = 1;
          dcnt = data_dly;
        end else req_cycles++;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    bus_exp_t  be;
    done_exp_t de;
    if (resetn) begin
      if (bus.data_sram_req) req_run++;
      if (bus.data_sram_req && pend && !bus.data_sram_addr_ok) overlap++;
      if (bus.data_sram_req && bus.data_sram_addr_ok) begin
        last_req_len = req_run;
        req_run = 0;
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: request at 0x%08h, none expected", bus.data_sram_addr);
        end else begin
          be = bus_q.pop_front();
          check("bus_wr",    {31'h0, bus.data_sram_wr},   {31'h0, be.wr});
          check("bus_size",  {30'h0, bus.data_sram_size}, {30'h0, be.size});
          check("bus_addr",  bus.data_sram_addr,          be.addr);
          check("bus_wstrb", {28'h0, bus.data_sram_wstrb}, {28'h0, be.wstrb});
          if (be.wr) check("bus_wdata", bus.data_sram_wdata, be.wdata);
        end
      end
      if (bus.ms_done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: ms_done with rdata 0x%08h, none expected", bus.ms_rdata);
        end else begin
          de = done_q.pop_front();
          if (de.is_load) check("ms_rdata", bus.ms_rdata, de.rdata);
          check("ms_adel", {31'h0, bus.ms_adel}, {31'h0, de.adel});
          check("ms_ades", {31'h0, bus.ms_ades}, {31'h0, de.ades});
          if (de.adel || de.ades) check("ms_badvaddr", bus.ms_badvaddr, de.badv);
        end
      end
    end else req_run = 0;
  end

  // ---------------- stimulus helpers ----------------
  task automatic expect_bus(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [3:0] wstrb, input logic [31:0] wdata,
                            input logic [31:0] rsp);
    bus_exp_t e;
    e.wr = wr; e.size = size; e.addr = addr; e.wstrb = wstrb; e.wdata = wdata;
    bus_q.push_back(e);
    rsp_data_q.push_back(rsp);
  endtask

  task automatic expect_done(input logic is_load, input logic [31:0] rdata,
                             input logic adel, input logic ades, input logic [31:0] badv);
    done_exp_t e;
    e.is_load = is_load; e.rdata = rdata; e.adel = adel; e.ades = ades; e.badv = badv;
    done_q.push_back(e);
  endtask

  task automatic present(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    bus.ms_valid = 1'b1;
    bus.ms_op    = op;
    bus.ms_addr  = addr;
    bus.ms_wdata = wdata;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after ms_done.
  task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int exp_lat);
    int t0;
    int n;
    bit got;
    bit stall_ok;
    t0 = cyc; n = 0; got = 0; stall_ok = 1;
    present(op, addr, wdata);
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.ms_done) begin
        got = 1;
        if (bus.ms_stall !== 1'b0) stall_ok = 0;
      end else if (bus.ms_stall !== 1'b1) stall_ok = 0;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no ms_done within 60 cycles", name);
    end else check({name, "_latency"}, cyc - t0, exp_lat);
    check({name, "_stall"}, {31'h0, stall_ok}, 32'h1);
    @(posedge clk); #1;
    bus.ms_valid = 1'b0;
    bus.ms_op    = 8'h0;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_req"},   {31'h0, bus.data_sram_req},   32'h0);
    check({name, "_wr"},    {31'h0, bus.data_sram_wr},    32'h0);
    check({name, "_size"},  {30'h0, bus.data_sram_size},  32'h0);
    check({name, "_addr"},  bus.data_sram_addr,           32'h0);
    check({name, "_wstrb"}, {28'h0, bus.data_sram_wstrb}, 32'h0);
    check({name, "_wdata"}, bus.data_sram_wdata,          32'h0);
    check({name, "_stall"}, {31'h0, bus.ms_stall},        32'h0);
    check({name, "_done"},  {31'h0, bus.ms_done},         32'h0);
    check({name, "_rdata"}, bus.ms_rdata,                 32'h0);
    check({name, "_adel"},  {31'h0, bus.ms_adel},         32'h0);
    check({name, "_ades"},  {31'h0, bus.ms_ades},         32'h0);
    check({name, "_badv"},  bus.ms_badvaddr,              32'h0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    resetn       = 1'b0;
    bus.ms_valid = 1'b0;
    bus.ms_op    = 8'h0;
    bus.ms_addr  = 32'h0;
    bus.ms_wdata = 32'h0;
    bus.ms_flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // LB, byte lane 3, sign extension, best-case latency
    expect_bus(1'b0, 2'd0, 32'h0000_1003, 4'b0000, 32'h0, 32'h80FF_FF00);
    expect_done(1'b1, 32'hFFFF_FF80, 1'b0, 1'b0, 32'h0);
    run_op("lb", OP_LB, 32'h0000_1003, 32'h0, 3);

    // SH upper half: strobes 1100, replicated data
    expect_bus(1'b1, 2'd1, 32'h0000_2002, 4'b1100, 32'hABCD_ABCD, 32'h0);
    expect_done(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    run_op("sh", OP_SH, 32'h0000_2002, 32'h1234_ABCD, 3);

    // Misaligned word load / half store
`ifdef DMEM_ADDR_EXC_EN
    expect_done(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_3001);
    run_op("lw_misalign", OP_LW, 32'h0000_3001, 32'h0, 1);
    expect_done(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_2001);
    run_op("sh_misalign", OP_SH, 32'h0000_2001, 32'h0000_BEEF, 1);
`else
    expect_bus(1'b0, 2'd2, 32'h0000_3001, 4'b0000, 32'h0, 32'h7654_3210);
    expect_done(1'b1, 32'h7654_3210, 1'b0, 1'b0, 32'h0);
    run_op("lw_misalign", OP_LW, 32'h0000_3001, 32'h0, 3);
    expect_bus(1'b1, 2'd1, 32'h0000_2001, 4'b0011, 32'hBEEF_BEEF, 32'h0);
    expect_done(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    run_op("sh_misalign", OP_SH, 32'h0000_2001, 32'h0000_BEEF, 3);
`endif

    // LHU with slow bus: 4 REQ cycles, 3 WAIT cycles, done right after data_ok
    addr_dly = 3; data_dly = 2;
    expect_bus(1'b0, 2'd1, 32'h0000_1002, 4'b0000, 32'h0, 32'hC0DE_8001);
    expect_done(1'b1, 32'h0000_C0DE, 1'b0, 1'b0, 32'h0);
    run_op("lhu_slow", OP_LHU, 32'h0000_1002, 32'h0, 8);
    check("lhu_req_len", last_req_len, 4);
    addr_dly = 0; data_dly = 0;

    // Back-to-back mix of loads and stores
    expect_bus(1'b1, 2'd0, 32'h0000_0011, 4'b0010, 32'h5A5A_5A5A, 32'h0);
    expect_done(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    run_op("sb", OP_SB, 32'h0000_0011, 32'h1122_335A, 3);
    expect_bus(1'b1, 2'd2, 32'h0000_0020, 4'b1111, 32'hCAFE_F00D, 32'h0);
    expect_done(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    run_op("sw", OP_SW, 32'h0000_0020, 32'hCAFE_F00D, 3);
    expect_bus(1'b0, 2'd1, 32'h0000_1002, 4'b0000, 32'h0, 32'h8001_7FFF);
    expect_done(1'b1, 32'hFFFF_8001, 1'b0, 1'b0, 32'h0);
    run_op("lh", OP_LH, 32'h0000_1002, 32'h0, 3);
    expect_bus(1'b0, 2'd0, 32'h0000_1001, 4'b0000, 32'h0, 32'h1234_F0AB);
    expect_done(1'b1, 32'h0000_00F0, 1'b0, 1'b0, 32'h0);
    run_op("lbu", OP_LBU, 32'h0000_1001, 32'h0, 3);

    // Valid instruction with no memory op: no stall, no request
    present(8'h00, 32'h0000_0040, 32'h0);
    @(negedge clk);
    check("noop_stall", {31'h0, bus.ms_stall}, 32'h0);
    check("noop_req", {31'h0, bus.data_sram_req}, 32'h0);
    @(posedge clk); #1;
    bus.ms_valid = 1'b0;

    // Flush in WAIT: old response dropped, new LW issued after it
    data_dly = 4;
    expect_bus(1'b0, 2'd2, 32'h0000_4000, 4'b0000, 32'h0, 32'hBAD0_BAD0);
    present(OP_LW, 32'h0000_4000, 32'h0);
    @(posedge clk); #1;                       // REQ, addr_ok
    @(posedge clk); #1;                       // WAIT
    bus.ms_flush = 1'b1; bus.ms_valid = 1'b0; bus.ms_op = 8'h0;
    @(posedge clk); #1;                       // DISCARD
    bus.ms_flush = 1'b0; data_dly = 0;
    expect_bus(1'b0, 2'd2, 32'h0000_5004, 4'b0000, 32'h0, 32'h1357_9BDF);
    expect_done(1'b1, 32'h1357_9BDF, 1'b0, 1'b0, 32'h0);
    run_op("flush_wait_next", OP_LW, 32'h0000_5004, 32'h0, 7);

    // Flush together with data_ok in WAIT: consumed, straight to IDLE
    expect_bus(1'b0, 2'd2, 32'h0000_4100, 4'b0000, 32'h0, 32'h0BAD_0BAD);
    present(OP_LW, 32'h0000_4100, 32'h0);
    @(posedge clk); #1;                       // REQ
    @(posedge clk); #1;                       // WAIT with data_ok
    bus.ms_flush = 1'b1; bus.ms_valid = 1'b0; bus.ms_op = 8'h0;
    @(posedge clk); #1;                       // IDLE
    bus.ms_flush = 1'b0;
    expect_bus(1'b0, 2'd0, 32'h0000_4102, 4'b0000, 32'h0, 32'h00A5_0000);
    expect_done(1'b1, 32'h0000_00A5, 1'b0, 1'b0, 32'h0);
    run_op("flush_dataok_next", OP_LBU, 32'h0000_4102, 32'h0, 3);

    // Flush in REQ: request held until addr_ok, then drained in DISCARD
    addr_dly = 2; data_dly = 1;
    expect_bus(1'b0, 2'd1, 32'h0000_4200, 4'b0000, 32'h0, 32'hFFFF_FFFF);
    present(OP_LH, 32'h0000_4200, 32'h0);
    @(posedge clk); #1;                       // REQ
    bus.ms_flush = 1'b1; bus.ms_valid = 1'b0; bus.ms_op = 8'h0;
    @(posedge clk); #1;                       // REQ
    bus.ms_flush = 1'b0;
    @(posedge clk); #1;                       // REQ, addr_ok
    @(posedge clk); #1;                       // DISCARD
    @(negedge clk);
    check("discard_stall", {31'h0, bus.ms_stall}, 32'h1);
    @(posedge clk); #1;                       // DISCARD, data_ok
    addr_dly = 0; data_dly = 0;
    expect_bus(1'b1, 2'd2, 32'h0000_4300, 4'b1111, 32'h0F0F_0F0F, 32'h0);
    expect_done(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    run_op("flush_req_next", OP_SW, 32'h0000_4300, 32'h0F0F_0F0F, 4);

    // Reset while in WAIT
    data_dly = 10;
    expect_bus(1'b0, 2'd2, 32'h0000_6000, 4'b0000, 32'h0, 32'h6666_6666);
    present(OP_LW, 32'h0000_6000, 32'h0);
    @(posedge clk); #1;                       // REQ
    @(posedge clk); #1;                       // WAIT
    resetn = 1'b0; bus.ms_valid = 1'b0; bus.ms_op = 8'h0;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("midreset");
    @(posedge clk); #1;
    resetn = 1'b1; data_dly = 0;
    @(posedge clk); #1;

    // Recovery after reset
    expect_bus(1'b0, 2'd2, 32'h0000_1000, 4'b0000, 32'h0, 32'hDEAD_BEEF);
    expect_done(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    run_op("lw_after_reset", OP_LW, 32'h0000_1000, 32'h0, 3);

    repeat (3) @(posedge clk);
    #1;
    check("bus_overlap", overlap, 0);
    check("bus_q_left", bus_q.size(), 0);
    check("done_q_left", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
